// File: rtl/lmdpl_share_decoder.sv
// Consumer end of the LMDPL masked dual-rail datapath: checks the dual-rail
// encoding of both shares, unmasks (share0 ^ share1) and hands it off via valid/ready.
module lmdpl_share_decoder #(
  parameter int WIDTH       = 4,
  parameter int TIMEOUT     = 15,
  parameter int FAULT_CNT_W = 8
) (
  input  logic                   UserCLK,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       A0_t,
  input  logic [WIDTH-1:0]       A0_f,
  input  logic [WIDTH-1:0]       A1_t,
  input  logic [WIDTH-1:0]       A1_f,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   clr_fault,
  output logic                   fault,
  output logic [1:0]             fault_cause,
  output logic [FAULT_CNT_W-1:0] fault_count
);

  localparam int NP    = 2 * WIDTH;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] C_NONE     = 2'b00;
  localparam logic [1:0] C_INVALID  = 2'b01;
  localparam logic [1:0] C_NONMONO  = 2'b10;
  localparam logic [1:0] C_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    S_WAIT_PRE,
    S_WAIT_EVAL,
    S_OUTPUT,
    S_FAULT
  } state_t;

  state_t                 r_state;
  logic [WIDTH-1:0]       r_out_data;
  logic                   r_out_valid;
  logic                   r_fault;
  logic [1:0]             r_fault_cause;
  logic [FAULT_CNT_W-1:0] r_fault_count;
  logic [NP-1:0]          r_seen_valid;
  logic [CNT_W-1:0]       r_cnt;

  // Pair i is (w_t[i], w_f[i]); share 0 occupies the low WIDTH pairs.
  logic [NP-1:0] w_t;
  logic [NP-1:0] w_f;
  logic [NP-1:0] w_pair_valid;
  logic          w_any_invalid;
  logic          w_all_pre;
  logic          w_all_valid;
  logic          w_nonmono;
  logic          w_timeout;
  logic          w_enter_fault;

  assign w_t           = {A1_t, A0_t};
  assign w_f           = {A1_f, A0_f};
  assign w_pair_valid  = w_t ^ w_f;
  assign w_any_invalid = |(w_t & w_f);
  assign w_all_pre     = ~|(w_t | w_f);
  assign w_all_valid   = &w_pair_valid;
  assign w_nonmono     = |(r_seen_valid & ~(w_t | w_f));
  assign w_timeout     = (r_cnt == CNT_LAST);

  // Mirrors the FSM's fault branches so the counter sees every entry into S_FAULT.
  assign w_enter_fault =
      ((r_state == S_WAIT_PRE)  && w_any_invalid) ||
      ((r_state == S_WAIT_EVAL) && (w_any_invalid || w_nonmono ||
                                    (!w_all_valid && w_timeout)));

  // NOTE: state is written with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge UserCLK) begin
    if (rst) begin
      r_state       <= S_WAIT_PRE;
      r_out_data    <= '0;
      r_out_valid   <= 1'b0;
      r_fault       <= 1'b0;
      r_fault_cause <= C_NONE;
      r_seen_valid  <= '0;
      r_cnt         <= '0;
    end else begin
      case (r_state)
        S_WAIT_PRE: begin
          if (w_any_invalid) begin
            r_state       <= S_FAULT;
            r_fault       <= 1'b1;
            r_fault_cause <= C_INVALID;
          end else if (w_all_pre) begin
            r_state      <= S_WAIT_EVAL;
            r_seen_valid <= '0;
            r_cnt        <= '0;
          end
        end
        S_WAIT_EVAL: begin
          if (w_any_invalid) begin
            r_state       <= S_FAULT;
            r_fault       <= 1'b1;
            r_fault_cause <= C_INVALID;
          end else if (w_nonmono) begin
            r_state       <= S_FAULT;
            r_fault       <= 1'b1;
            r_fault_cause <= C_NONMONO;
          end else if (w_all_valid) begin
            // Completion outranks a counter expiring in the same cycle.
            r_state     <= S_OUTPUT;
            r_out_valid <= 1'b1;
            r_out_data  <= A0_t ^ A1_t;
          end else if (w_timeout) begin
            r_state       <= S_FAULT;
            r_fault       <= 1'b1;
            r_fault_cause <= C_TIMEOUT;
          end else begin
            r_cnt        <= r_cnt + CNT_W'(1);
            r_seen_valid <= r_seen_valid | w_pair_valid;
          end
        end
        S_OUTPUT: begin
          if (out_ready) begin
            r_state     <= S_WAIT_PRE;
            r_out_valid <= 1'b0;
          end
        end
        S_FAULT: begin
          if (clr_fault) begin
            r_state       <= S_WAIT_PRE;
            r_fault       <= 1'b0;
            r_fault_cause <= C_NONE;
          end
        end
        default: r_state <= S_WAIT_PRE;
      endcase
    end
  end

  // Survives clr_fault; only rst clears the history.
  always_ff @(posedge UserCLK) begin
    if (rst) begin
      r_fault_count <= '0;
    end else if (w_enter_fault && !(&r_fault_count)) begin
      r_fault_count <= r_fault_count + FAULT_CNT_W'(1);
    end
  end

  assign out_data    = r_out_data;
  assign out_valid   = r_out_valid;
  assign fault       = r_fault;
  assign fault_cause = r_fault_cause;
  assign fault_count = r_fault_count;

endmodule

// File: tb/tb_lmdpl_share_decoder.sv
// Directed plus randomized bench for lmdpl_share_decoder against a pair-level
// behavioural model; a second instance with a 2-bit fault counter covers saturation.
module tb_lmdpl_share_decoder;

  localparam int W  = 4;
  localparam int TO = 15;
  localparam int NP = 2 * W;

  logic         UserCLK = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] A0_t = '0, A0_f = '0, A1_t = '0, A1_f = '0;
  logic         out_ready = 1'b0;
  logic         clr_fault = 1'b0;

  logic [W-1:0] out_data;
  logic         out_valid, fault;
  logic [1:0]   fault_cause;
  logic [7:0]   fault_count;

  logic [W-1:0] s_out_data;
  logic         s_out_valid, s_fault;
  logic [1:0]   s_fault_cause;
  logic [1:0]   s_fault_count;

  always #5 UserCLK = ~UserCLK;

  lmdpl_share_decoder #(.WIDTH(W), .TIMEOUT(TO), .FAULT_CNT_W(8)) dut (
    .UserCLK(UserCLK), .rst(rst),
    .A0_t(A0_t), .A0_f(A0_f), .A1_t(A1_t), .A1_f(A1_f),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .clr_fault(clr_fault), .fault(fault), .fault_cause(fault_cause),
    .fault_count(fault_count)
  );

  lmdpl_share_decoder #(.WIDTH(W), .TIMEOUT(TO), .FAULT_CNT_W(2)) dut_sat (
    .UserCLK(UserCLK), .rst(rst),
    .A0_t(A0_t), .A0_f(A0_f), .A1_t(A1_t), .A1_f(A1_f),
    .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(out_ready),
    .clr_fault(clr_fault), .fault(s_fault), .fault_cause(s_fault_cause),
    .fault_count(s_fault_count)
  );

  int    n_checks = 0;
  int    n_pass   = 0;
  string phase    = "reset";

  // Reference model: 0 waiting for precharge, 1 evaluating, 2 presenting, 3 faulted.
  int           m_mode   = 0;
  bit           m_seen[NP];
  int           m_evalc  = 0;
  logic [W-1:0] m_data   = '0;
  bit           m_valid  = 1'b0;
  bit           m_fault  = 1'b0;
  logic [1:0]   m_cause  = 2'b00;
  int           m_faults = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s.%s observed=%0h expected=%0h", phase, tag, obs, exp);
  endtask

  function automatic logic [1:0] pair_code(input int i);
    if (i < W) return {A0_t[i], A0_f[i]};
    return {A1_t[i-W], A1_f[i-W]};
  endfunction

  function automatic int sat(input int n, input int max);
    return (n > max) ? max : n;
  endfunction

  task automatic enter_fault(input logic [1:0] c);
    m_mode  = 3;
    m_fault = 1'b1;
    m_cause = c;
    m_faults++;
  endtask

  task automatic model_step();
    bit         inv, pre, allv, regress;
    logic [1:0] p;
    logic [1:0] q;
    if (rst) begin
      m_mode = 0; m_evalc = 0; m_data = '0; m_valid = 0;
      m_fault = 0; m_cause = 2'b00; m_faults = 0;
      for (int i = 0; i < NP; i++) m_seen[i] = 0;
      return;
    end
    inv = 0; pre = 1; allv = 1; regress = 0;
    for (int i = 0; i < NP; i++) begin
      p = pair_code(i);
      if (p == 2'b11) inv = 1;
      if (p != 2'b00) pre = 0;
      if (p != 2'b01 && p != 2'b10) allv = 0;
      if (m_seen[i] && p == 2'b00) regress = 1;
    end
    case (m_mode)
      0: begin
        if (inv) enter_fault(2'b01);
        else if (pre) begin
          m_mode = 1; m_evalc = 0;
          for (int i = 0; i < NP; i++) m_seen[i] = 0;
        end
      end
      1: begin
        if (inv) enter_fault(2'b01);
        else if (regress) enter_fault(2'b10);
        else if (allv) begin
          m_mode = 2; m_valid = 1;
          for (int b = 0; b < W; b++) begin
            p = pair_code(b);
            q = pair_code(b + W);
            m_data[b] = p[1] ^ q[1];
          end
        end else if (m_evalc + 1 >= TO) enter_fault(2'b11);
        else begin
          m_evalc++;
          for (int i = 0; i < NP; i++) begin
            p = pair_code(i);
            if (p == 2'b01 || p == 2'b10) m_seen[i] = 1;
          end
        end
      end
      2: if (out_ready) begin m_mode = 0; m_valid = 0; end
      default: if (clr_fault) begin m_mode = 0; m_fault = 0; m_cause = 2'b00; end
    endcase
  endtask

  task automatic tick();
    model_step();
    @(posedge UserCLK);
    #1;
    check("out_valid",     out_valid,     m_valid);
    check("out_data",      out_data,      m_data);
    check("fault",         fault,         m_fault);
    check("fault_cause",   fault_cause,   m_cause);
    check("fault_count",   fault_count,   sat(m_faults, 255));
    check("s_out_valid",   s_out_valid,   m_valid);
    check("s_out_data",    s_out_data,    m_data);
    check("s_fault",       s_fault,       m_fault);
    check("s_fault_cause", s_fault_cause, m_cause);
    check("s_fault_count", s_fault_count, sat(m_faults, 3));
  endtask

  task automatic drive(input logic [NP-1:0] t, input logic [NP-1:0] f);
    {A1_t, A0_t} = t;
    {A1_f, A0_f} = f;
  endtask

  task automatic clear_fault();
    drive('0, '0);
    clr_fault = 1'b1;
    tick();
    clr_fault = 1'b0;
  endtask

  initial begin
    logic [NP-1:0] t_acc, f_acc, v;
    int            r, bad;

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    phase = "nominal";
    drive('0, '0);
    tick();
    drive({4'b0110, 4'b1010}, ~{4'b0110, 4'b1010});
    tick();
    check("data_1100", out_data, 4'b1100);
    check("valid_one_cycle", out_valid, 1'b1);
    for (int k = 0; k < 3; k++) tick();
    check("valid_held", out_valid, 1'b1);
    out_ready = 1'b1;
    tick();
    check("valid_dropped", out_valid, 1'b0);
    out_ready = 1'b0;

    phase = "stagger";
    drive('0, '0);
    tick();
    v = NP'($urandom);
    t_acc = '0; f_acc = '0;
    for (int k = 0; k < NP; k++) begin
      t_acc[k] = v[k];
      f_acc[k] = ~v[k];
      drive(t_acc, f_acc);
      tick();
    end
    check("valid_after_last", out_valid, 1'b1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    phase = "invalid";
    drive('0, '0);
    tick();
    drive('0, '0);
    A1_t[2] = 1'b1;
    A1_f[2] = 1'b1;
    tick();
    check("cause_01", fault_cause, 2'b01);
    check("count_1", fault_count, 8'd1);
    clear_fault();
    check("fault_cleared", fault, 1'b0);
    check("count_kept", fault_count, 8'd1);

    phase = "nonmono";
    tick();
    drive(NP'(1), '0);
    tick();
    drive('0, '0);
    tick();
    check("cause_10", fault_cause, 2'b10);
    clear_fault();

    phase = "timeout";
    tick();
    drive({4'h0, 4'b0101}, {4'h0, 4'b1010});
    for (int k = 0; k < TO - 1; k++) tick();
    check("no_fault_yet", fault, 1'b0);
    tick();
    check("cause_11", fault_cause, 2'b11);
    clear_fault();

    phase = "last_cycle";
    tick();
    drive({4'h0, 4'b0101}, {4'h0, 4'b1010});
    for (int k = 0; k < TO - 1; k++) tick();
    drive({4'b0011, 4'b0101}, {4'b1100, 4'b1010});
    tick();
    check("completion_wins", fault, 1'b0);
    check("completion_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    phase = "saturate";
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(NP'(1), NP'(1));
      tick();
      clear_fault();
    end
    check("sat_count", s_fault_count, 2'd3);
    check("wide_count", fault_count, 8'd5);

    phase = "rst_in_output";
    tick();
    v = NP'($urandom);
    drive(v, ~v);
    tick();
    out_ready = 1'b1;
    rst = 1'b1;
    tick();
    check("rst_valid", out_valid, 1'b0);
    check("rst_count", fault_count, 8'd0);
    rst = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    check("needs_precharge", out_valid, 1'b0);
    drive('0, '0);
    tick();
    drive(v, ~v);
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    phase = "random";
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 9);
      t_acc = '0; f_acc = '0;
      if (r >= 3) begin
        bad = (r == 9) ? $urandom_range(0, NP - 1) : -1;
        for (int i = 0; i < NP; i++) begin
          case ((i == bad) ? 3 : ((r <= 5) ? $urandom_range(1, 2) : $urandom_range(0, 2)))
            1: f_acc[i] = 1'b1;
            2: t_acc[i] = 1'b1;
            3: begin t_acc[i] = 1'b1; f_acc[i] = 1'b1; end
            default: ;
          endcase
        end
      end
      drive(t_acc, f_acc);
      out_ready = ($urandom_range(0, 2) != 0);
      clr_fault = ($urandom_range(0, 3) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    clr_fault = 1'b0;
    out_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lmdpl_share_decoder.md
Name: lmdpl_share_decoder

Overview:
- Consumer end of the LMDPL masked dual-rail datapath. Receives a WIDTH-bit value as two dual-rail shares (share 0 and share 1), each bit on a (_t, _f) pair.
- Tracks the precharge/evaluate sequence and checks the dual-rail encoding for faults. Unmasks the value (share0 XOR share1) and hands it off over a valid/ready interface.
- Sits at the fabric boundary, where masked results leave the protected LMDPL region.

Parameters:
- WIDTH, 4, number of data bits per share.
- TIMEOUT, 15, maximum cycles spent in WAIT_EVAL before a timeout fault (>=1).
- FAULT_CNT_W, 8, width of the saturating fault counter.

Ports:
- UserCLK  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- A0_t  in  WIDTH  share 0 true rails.
- A0_f  in  WIDTH  share 0 false rails.
- A1_t  in  WIDTH  share 1 true rails.
- A1_f  in  WIDTH  share 1 false rails.
- out_data  out  WIDTH  unmasked value.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- clr_fault  in  1  one-cycle pulse; leaves FAULT.
- fault  out  1  sticky fault flag.
- fault_cause  out  2  00 none, 01 invalid rail (11), 10 non-monotonic, 11 timeout.
- fault_count  out  FAULT_CNT_W  saturating count of fault events.

Behaviour:
- Clock and reset: one clock, UserCLK. Reset is synchronous, active-high, on rst.
- Pair encoding: 00 = precharge, 01 = logic 0, 10 = logic 1, 11 = invalid. There are 2*WIDTH pairs. Share bit value = _t rail.
- Per-cycle flags, evaluated on the registered-free inputs:
  - any_invalid: some pair is 11.
  - all_pre: all pairs are 00.
  - all_valid: all pairs are 01 or 10.
  - nonmono: some pair that was valid earlier in this evaluation (seen_valid[i]=1) is now 00.
- FSM: WAIT_PRE, WAIT_EVAL, OUTPUT, FAULT. Reset state is WAIT_PRE.
- WAIT_PRE:
  - any_invalid -> FAULT, cause 01.
  - else all_pre -> WAIT_EVAL; clear seen_valid and the timeout counter.
  - else stay. There is no timeout in this state.
- WAIT_EVAL, checked in priority order:
  - any_invalid -> FAULT, cause 01.
  - else nonmono -> FAULT, cause 10.
  - else all_valid -> OUTPUT; latch out_data = A0_t ^ A1_t.
  - else if counter == TIMEOUT-1 -> FAULT, cause 11.
  - else stay: counter+1, seen_valid |= per-pair valid.
  - If completion occurs in the same cycle the counter expires, completion wins.
- OUTPUT:
  - out_valid=1; out_data held stable.
  - out_ready=1 -> WAIT_PRE with out_valid=0 the next cycle.
  - Inputs are ignored while in OUTPUT; no faults are detected here.
- FAULT:
  - fault=1 and fault_cause held.
  - clr_fault=1 -> WAIT_PRE; fault and cause cleared the next cycle.
- Latency: a condition sampled in cycle N is visible on the outputs in cycle N+1 (out_valid, fault, cause). out_valid rises one cycle after all pairs become valid.
- fault_count: +1 on each transition into FAULT; saturates at all-ones. Cleared only by rst; clr_fault does not clear it.
- Reset values: out_data=0, out_valid=0, fault=0, fault_cause=00, fault_count=0, seen_valid=0, counter=0.
- Reset mid-operation: any state, including OUTPUT with a pending handshake, abandons the operation and returns to WAIT_PRE; the pending output is dropped.
- rst has priority over clr_fault and out_ready.
- Partial evaluation (some pairs still 00, none invalid, none regressed) is legal and waits.

Test Plan:
- Nominal: reset, then all rails 0 for 1 cycle, then share0=1010 and share1=0110 (complementary _f). Required: out_valid=1 with out_data=1100 exactly one cycle later; it holds with out_ready=0 for 3 cycles, and out_valid drops the cycle after out_ready=1.
- Staggered evaluate: after precharge, pairs become valid one per cycle over 8 cycles. Required: no fault, and out_valid follows one cycle after the last pair.
- Invalid rail: in WAIT_EVAL drive A1_t[2]=A1_f[2]=1. Required: next cycle fault=1, cause=01, count=1, out_valid stays 0. A clr_fault pulse returns to WAIT_PRE with fault=0 and count still 1.
- Non-monotonic and timeout:
  - A0 bit0 goes 10 then back to 00 -> cause 10.
  - A separate run holds only half the pairs valid -> cause 11 after exactly 15 cycles in WAIT_EVAL.
  - A run completing on cycle 15 -> no fault.
- Saturation and reset: with FAULT_CNT_W=2, inject 5 faults -> count stays 3. Assert rst during OUTPUT -> next cycle out_valid=0, count=0, state WAIT_PRE (a new output needs a fresh precharge).
